multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Multi-cycle RISC-V control FSM: the driving end of the ALU interface.
- Sequences each instruction through IF/ID/EX/MEM/WB and issues alu_op and the datapath mux selects.
- Consumes the ALU's alu_bcond to resolve branches.
- Handshakes with a variable-latency memory via mem_ready. Sits beside the ALU, register file, IR/MDR/ALUOut registers and PC.

Parameters:
- OPCODE_W, 7, opcode field width
- ALU_OP_W, 4, alu_op width; must match the ALU

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- alu_bcond  in  1  branch-condition result from the ALU
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_op  out  4  ALU operation code
- alu_src_a  out  1  0=PC, 1=rs1 (A reg)
- alu_src_b  out  2  0=rs2 (B reg), 1=const 4, 2=imm
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR (and MDR) from memory data
- reg_write  out  1  register file write enable
- wb_src  out  2  0=ALUOut, 1=MDR, 2=ALU result
- pc_write  out  1  PC write enable
- pc_source  out  1  0=ALU result, 1=ALUOut
- halted  out  1  sticky stop flag

Behaviour:
- Reset: asynchronous while reset_n=0. State goes to IF, halted clears, and all outputs are forced to 0 regardless of state. Reset may arrive mid-instruction; the in-flight instruction is abandoned and nothing is written. The first cycle after release is IF.
- Output timing: outputs decode combinationally from state, plus funct/alu_bcond/mem_ready where noted. State updates on the rising clk edge.
- ALU codes (shared header): ADD=0, SUB=1, OR=2, AND=3, SLL=4, SRL=5, XOR=6, BEQ=7, BNE=8, BLT=9, BGE=10.
- Opcodes:
  - R=0110011, I=0010011, LOAD=0000011, STORE=0100011
  - BRANCH=1100011, JAL=1101111, JALR=1100111, ECALL=1110011
- IF: mem_read=1, i_or_d=0. Held until mem_ready=1. In that cycle ir_write=1 and next state is ID.
- ID: alu_src_a=0, alu_src_b=2, alu_op=ADD; PC+imm is latched into ALUOut. Next state by opcode:
  - ECALL or unknown opcode -> HALT
  - all other known opcodes -> EX
- EX, by opcode:
  - R/I: A op (B or imm) -> ALUOut; next WB.
  - LOAD/STORE: A+imm (ADD) -> ALUOut; next MEM.
  - BRANCH: src A=rs1, B=rs2, alu_op from funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, other -> HALT). If alu_bcond=1: pc_write=1, pc_source=1, next IF. If alu_bcond=0: next BR_NT.
  - JAL: ALU PC+4; reg_write=1, wb_src=2, pc_write=1, pc_source=1; next IF.
  - JALR: A+imm -> ALUOut; next WB.
- R/I alu_op decode from funct3:
  - 000: ADD, or SUB when R-type and funct7[5]=1
  - 001: SLL
  - 100: XOR
  - 101: SRL
  - 110: OR
  - 111: AND
  - 010, 011, and 101 with funct7[5]=1: HALT
- MEM: i_or_d=1, with mem_read (LOAD) or mem_write (STORE) held until mem_ready.
  - LOAD on ready: ir_write=0, MDR latched; next WB.
  - STORE on ready: ALU PC+4, pc_write=1, pc_source=0; next IF.
- WB: ALU computes PC+4; pc_write=1, pc_source=0, reg_write=1.
  - R/I: wb_src=0
  - LOAD: wb_src=1
  - JALR: wb_src=2 (PC+4 to rd) and pc_source=1 (target)
  - Next IF.
- BR_NT: ALU PC+4, pc_write=1, pc_source=0; next IF.
- HALT: halted=1, all other outputs 0. Absorbing until reset.
- Latency with mem_ready=1 on first request: R/I 4 cycles, LOAD 5, STORE 4, branch taken 3, branch not-taken 4, JAL 3, JALR 4. Each memory wait cycle adds 1.

Decomposition:
- Shared header holds: ALU_* codes (shared with the ALU), opcode constants, and state encodings IF, ID, EX, MEM, WB, BR_NT, HALT (3-bit).
- One sub-module, alu_control_unit: combinational (opcode, funct3, funct7) -> alu_op plus an illegal flag.

Test Plan:
- ADD (R, funct3=0, funct7=0), mem_ready=1 -> IF,ID,EX,WB. EX alu_op=0. WB reg_write=1, wb_src=0, pc_write=1. Back in IF on cycle 5.
- SUB (funct7=0100000) -> EX alu_op=1. The same funct7 with I-type opcode -> alu_op=0.
- BEQ, alu_bcond=1 in EX -> pc_write=1, pc_source=1, IF next (3 cycles). With alu_bcond=0 -> BR_NT, pc_source=0 (4 cycles).
- LOAD, mem_ready low for 2 cycles in MEM -> mem_read=1, i_or_d=1 for 3 cycles. Then WB with wb_src=1. Total 7 cycles.
- reset_n pulled low mid-MEM of a STORE -> mem_write drops to 0 the same cycle, no pc_write. After release, IF with mem_read=1.
- Opcode 0000000 or ECALL -> HALT after ID. halted=1 and stays 1 over 10 cycles; cleared only by reset_n=0.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg
//   Shared definitions for the multi-cycle RISC-V control path:
//   - ALU operation codes (must stay bit-identical with the ALU)
//   - RV32 major opcodes recognised by the controller
//   - FSM state encoding (3 bits)
//   - Datapath mux select encodings
//   - ctrl_t: the full bundle of control outputs, so every state only
//     has to override the fields it drives
package multi_cycle_control_pkg;

  localparam int OPCODE_W_P = 7;
  localparam int ALU_OP_W_P = 4;

  // ALU operation codes
  localparam logic [ALU_OP_W_P-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W_P-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W_P-1:0] ALU_OR  = 4'd2;
  localparam logic [ALU_OP_W_P-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_OP_W_P-1:0] ALU_SLL = 4'd4;
  localparam logic [ALU_OP_W_P-1:0] ALU_SRL = 4'd5;
  localparam logic [ALU_OP_W_P-1:0] ALU_XOR = 4'd6;
  localparam logic [ALU_OP_W_P-1:0] ALU_BEQ = 4'd7;
  localparam logic [ALU_OP_W_P-1:0] ALU_BNE = 4'd8;
  localparam logic [ALU_OP_W_P-1:0] ALU_BLT = 4'd9;
  localparam logic [ALU_OP_W_P-1:0] ALU_BGE = 4'd10;

  // Major opcodes
  localparam logic [OPCODE_W_P-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W_P-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W_P-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W_P-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W_P-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W_P-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W_P-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W_P-1:0] OP_ECALL  = 7'b1110011;

  // Mux select encodings
  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_RS1  = 1'b1;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_4    = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;
  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_ALU     = 2'd2;
  localparam logic       PCS_ALU    = 1'b0;
  localparam logic       PCS_ALUOUT = 1'b1;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_BR_NT = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  typedef struct packed {
    logic [ALU_OP_W_P-1:0] alu_op;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  reg_write;
    logic [1:0]            wb_src;
    logic                  pc_write;
    logic                  pc_source;
    logic                  halted;
  } ctrl_t;

  // Opcodes that get past ID; ECALL is recognised but stops the machine.
  function automatic logic is_exec_op(logic [OPCODE_W_P-1:0] op);
    return (op == OP_R)      || (op == OP_I)   || (op == OP_LOAD) ||
           (op == OP_STORE)  || (op == OP_BRANCH) ||
           (op == OP_JAL)    || (op == OP_JALR);
  endfunction

  // Sequential PC advance: ALU computes PC+4 and the result goes to PC.
  function automatic ctrl_t ctrl_pc_plus4(ctrl_t c);
    ctrl_t r;
    r           = c;
    r.alu_src_a = SRC_A_PC;
    r.alu_src_b = SRC_B_4;
    r.alu_op    = ALU_ADD;
    r.pc_write  = 1'b1;
    r.pc_source = PCS_ALU;
    return r;
  endfunction

endpackage

// File: rtl/multi_cycle_control_alu_control_unit.sv
// alu_control_unit
//   Combinational ALU-operation decode from the instruction fields.
//   Ports:
//     i_opcode  IR[6:0]
//     i_funct3  IR[14:12]
//     i_funct7  IR[31:25] (only bit 5 is meaningful)
//     o_alu_op  ALU operation for the EX stage
//     o_illegal funct combination (or opcode) the EX stage cannot execute
module alu_control_unit
  import multi_cycle_control_pkg::*;
(
  input  logic [OPCODE_W_P-1:0] i_opcode,
  input  logic [2:0]            i_funct3,
  input  logic [6:0]            i_funct7,
  output logic [ALU_OP_W_P-1:0] o_alu_op,
  output logic                  o_illegal
);

  logic w_alt;       // funct7[5]: SUB / arithmetic-shift selector
  logic w_unused_f7;

  assign w_alt       = i_funct7[5];
  assign w_unused_f7 = ^{i_funct7[6], i_funct7[4:0]};

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R, OP_I: begin
        case (i_funct3)
          3'b000: o_alu_op = (i_opcode == OP_R && w_alt) ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_op = ALU_SLL;
          3'b100: o_alu_op = ALU_XOR;
          3'b101: begin
            // Arithmetic right shift is not supported by the ALU.
            if (w_alt) o_illegal = 1'b1;
            else       o_alu_op  = ALU_SRL;
          end
          3'b110: o_alu_op = ALU_OR;
          3'b111: o_alu_op = ALU_AND;
          default: o_illegal = 1'b1; // SLT/SLTU not supported
        endcase
      end
      OP_BRANCH: begin
        case (i_funct3)
          3'b000:  o_alu_op  = ALU_BEQ;
          3'b001:  o_alu_op  = ALU_BNE;
          3'b100:  o_alu_op  = ALU_BLT;
          3'b101:  o_alu_op  = ALU_BGE;
          default: o_illegal = 1'b1;  // unsigned compares not supported
        endcase
      end
      // Address generation and link computation are plain adds.
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR: o_alu_op = ALU_ADD;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//   Multi-cycle RISC-V control FSM (IF/ID/EX/MEM/WB + BR_NT + HALT).
//   Drives the ALU op and datapath mux selects, resolves branches from
//   alu_bcond, and handshakes with a variable-latency memory via mem_ready.
//   Ports:
//     clk, reset_n         clock, async active-low reset
//     opcode/funct3/funct7 instruction fields from IR
//     alu_bcond            branch condition from the ALU
//     mem_ready            memory completes the current access this cycle
//     alu_op               ALU operation code
//     alu_src_a/_b         ALU operand selects
//     i_or_d               memory address select (PC / ALUOut)
//     mem_read/mem_write   memory requests
//     ir_write             load IR (and MDR)
//     reg_write, wb_src    register-file write enable / data select
//     pc_write, pc_source  PC write enable / next-PC select
//     halted               sticky stop flag
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int OPCODE_W = 7,
  parameter int ALU_OP_W = 4   // must equal the ALU's op width
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_bcond,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [1:0]          wb_src,
  output logic                pc_write,
  output logic                pc_source,
  output logic                halted
);

  state_e                r_state;
  state_e                w_next;
  ctrl_t                 w_ctrl;
  ctrl_t                 w_out;
  logic [ALU_OP_W_P-1:0] w_alu_op;
  logic                  w_illegal;

  alu_control_unit u_alu_ctrl (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .i_funct7  (funct7),
    .o_alu_op  (w_alu_op),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IF;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      S_IF: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b0;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_next          = S_ID;
        end
      end

      S_ID: begin
        // Speculative branch target PC+imm lands in ALUOut.
        w_ctrl.alu_src_a = SRC_A_PC;
        w_ctrl.alu_src_b = SRC_B_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        w_next           = is_exec_op(opcode) ? S_EX : S_HALT;
      end

      S_EX: begin
        if (w_illegal) begin
          w_next = S_HALT;
        end else begin
          case (opcode)
            OP_R, OP_I: begin
              w_ctrl.alu_src_a = SRC_A_RS1;
              w_ctrl.alu_src_b = (opcode == OP_R) ? SRC_B_RS2 : SRC_B_IMM;
              w_ctrl.alu_op    = w_alu_op;
              w_next           = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              w_ctrl.alu_src_a = SRC_A_RS1;
              w_ctrl.alu_src_b = SRC_B_IMM;
              w_ctrl.alu_op    = ALU_ADD;
              w_next           = S_MEM;
            end
            OP_BRANCH: begin
              w_ctrl.alu_src_a = SRC_A_RS1;
              w_ctrl.alu_src_b = SRC_B_RS2;
              w_ctrl.alu_op    = w_alu_op;
              if (alu_bcond) begin
                // Taken: target computed during ID is waiting in ALUOut.
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCS_ALUOUT;
                w_next           = S_IF;
              end else begin
                w_next = S_BR_NT;
              end
            end
            OP_JAL: begin
              // Link PC+4 straight from the ALU; jump to ALUOut (PC+imm).
              w_ctrl           = ctrl_pc_plus4(w_ctrl);
              w_ctrl.reg_write = 1'b1;
              w_ctrl.wb_src    = WB_ALU;
              w_ctrl.pc_source = PCS_ALUOUT;
              w_next           = S_IF;
            end
            OP_JALR: begin
              w_ctrl.alu_src_a = SRC_A_RS1;
              w_ctrl.alu_src_b = SRC_B_IMM;
              w_ctrl.alu_op    = ALU_ADD;
              w_next           = S_WB;
            end
            default: w_next = S_HALT;
          endcase
        end
      end

      S_MEM: begin
        w_ctrl.i_or_d = 1'b1;
        if (opcode == OP_LOAD) begin
          w_ctrl.mem_read = 1'b1;
          if (mem_ready) w_next = S_WB;   // MDR captures the data
        end else if (opcode == OP_STORE) begin
          w_ctrl.mem_write = 1'b1;
          if (mem_ready) begin
            w_ctrl = ctrl_pc_plus4(w_ctrl);
            w_next = S_IF;
          end
        end else begin
          w_next = S_HALT;
        end
      end

      S_WB: begin
        w_ctrl           = ctrl_pc_plus4(w_ctrl);
        w_ctrl.reg_write = 1'b1;
        case (opcode)
          OP_LOAD: w_ctrl.wb_src = WB_MDR;
          OP_JALR: begin
            // rd gets PC+4 from the ALU; the target (rs1+imm) is in ALUOut.
            w_ctrl.wb_src    = WB_ALU;
            w_ctrl.pc_source = PCS_ALUOUT;
          end
          default: w_ctrl.wb_src = WB_ALUOUT;
        endcase
        w_next = S_IF;
      end

      S_BR_NT: begin
        w_ctrl = ctrl_pc_plus4(w_ctrl);
        w_next = S_IF;
      end

      S_HALT: begin
        w_ctrl.halted = 1'b1;
      end

      default: w_next = S_HALT;
    endcase
  end

  // While reset is asserted every output is held low so an abandoned
  // instruction can never write memory, registers or PC.
  assign w_out     = reset_n ? w_ctrl : '0;

  assign alu_op    = w_out.alu_op;
  assign alu_src_a = w_out.alu_src_a;
  assign alu_src_b = w_out.alu_src_b;
  assign i_or_d    = w_out.i_or_d;
  assign mem_read  = w_out.mem_read;
  assign mem_write = w_out.mem_write;
  assign ir_write  = w_out.ir_write;
  assign reg_write = w_out.reg_write;
  assign wb_src    = w_out.wb_src;
  assign pc_write  = w_out.pc_write;
  assign pc_source = w_out.pc_source;
  assign halted    = w_out.halted;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed scenarios followed by
// randomized instructions, compared against an instruction-level model
// (latency formula, write counts, expected selects).
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       alu_bcond = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] wb_src;
  logic       pc_write, pc_source, halted;
  logic [16:0] all_outs;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4,
                 K_JAL = 5, K_JALR = 6, K_ECALL = 7, K_BAD = 8;

  logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011};
  // funct3 -> ALU code; -1 marks an encoding that stops the machine
  int alu_tab [8] = '{0, 4, -1, -1, 6, 5, 2, 3};
  int br_tab  [8] = '{7, 8, -1, -1, 9, 10, -1, -1};

  always #5 clk = ~clk;

  assign all_outs = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
                     ir_write, reg_write, wb_src, pc_write, pc_source, halted};

  multi_cycle_control #(.OPCODE_W(7), .ALU_OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .wb_src(wb_src),
    .pc_write(pc_write), .pc_source(pc_source), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_alu(input int kind, input logic [2:0] f3, input logic [6:0] f7);
    int v;
    if (kind == K_BR) v = br_tab[f3];
    else if (kind == K_R || kind == K_I) begin
      v = alu_tab[f3];
      if (f7[5] && f3 == 3'd5) v = -1;
      if (f7[5] && f3 == 3'd0 && kind == K_R) v = 1;
    end else if (kind >= K_ECALL) v = -1;
    else v = 0;
    return v;
  endfunction

  function automatic int m_latency(input int kind, input bit bc, input int wif, input int wmem);
    int extra;
    case (kind)
      K_R, K_I, K_JALR: extra = 1;
      K_LD:             extra = 2 + wmem;
      K_ST:             extra = 1 + wmem;
      K_BR:             extra = bc ? 0 : 1;
      default:          extra = 0;
    endcase
    return 3 + wif + extra;
  endfunction

  // Runs one instruction starting at the negedge that opens its IF cycle.
  // Returns at the negedge opening the next IF cycle, or in HALT.
  task automatic run_instr(input int kind, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input bit bc, input int wif,
                           input int wmem, output bit hit_halt);
    int  e_alu, lat, ir_k, nif, nmem, nrw, npw, nir, obs_wb, obs_ps, ex_alu, id_b, id_alu;
    bit  got_ir, ended, e_rw;
    e_alu  = m_alu(kind, f3, f7);
    e_rw   = (kind == K_R || kind == K_I || kind == K_LD || kind == K_JAL || kind == K_JALR);
    got_ir = 0; ended = 0; hit_halt = 0; lat = 0;
    ir_k = -10; nif = 0; nmem = 0; nrw = 0; npw = 0; nir = 0;
    obs_wb = -1; obs_ps = -1; ex_alu = -1; id_b = -1; id_alu = -1;
    opcode = op; funct3 = f3; funct7 = f7; alu_bcond = bc;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (halted) begin hit_halt = 1; ended = 1; break; end
      if (got_ir && mem_read && !i_or_d) begin lat = k; ended = 1; break; end
      if (mem_read && !i_or_d) begin
        mem_ready = (nif == wif); nif++;
      end else if (i_or_d && (mem_read || mem_write)) begin
        mem_ready = (nmem == wmem); nmem++;
      end else mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (ir_write) begin got_ir = 1; ir_k = k; nir++; end
      if (k == ir_k + 1) begin id_b = alu_src_b; id_alu = alu_op; end
      if (k == ir_k + 2) ex_alu = alu_op;
      if (reg_write) begin nrw++; obs_wb = wb_src; end
      if (pc_write)  begin npw++; obs_ps = pc_source; end
    end
    chk("ended_in_bound", ended, 1);
    chk("id_src_b", id_b, 2);
    chk("id_alu_add", id_alu, 0);
    chk("halt_expect", hit_halt, (e_alu < 0));
    if (ended && !hit_halt && e_alu >= 0) begin
      chk("latency", lat, m_latency(kind, bc, wif, wmem));
      chk("ex_alu_op", ex_alu, e_alu);
      chk("ir_write_cnt", nir, 1);
      chk("reg_write_cnt", nrw, e_rw);
      if (e_rw) chk("wb_src", obs_wb, (kind == K_LD) ? 1 : (kind >= K_JAL) ? 2 : 0);
      chk("pc_write_cnt", npw, 1);
      chk("pc_source", obs_ps, (kind == K_JAL || kind == K_JALR || (kind == K_BR && bc)));
      chk("mem_data_cycles", nmem, (kind == K_LD || kind == K_ST) ? wmem + 1 : 0);
    end
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      mem_ready = 1'($urandom); alu_bcond = 1'($urandom);
      #1 chk("halt_sticky_quiet", all_outs, 17'h1);
    end
  endtask

  // Short reset pulse between clock edges: must act without a clock edge.
  task automatic clear_halt();
    @(negedge clk);
    mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    #1;
    chk("async_halt_clear", halted, 0);
    chk("async_if_state", {mem_read, i_or_d}, 2'b10);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         h;
    int         kind, wif, wmem;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit         known;

    // Reset state
    #2;
    chk("rst_outs_zero", all_outs, 0);
    @(posedge clk); #1;
    chk("rst_outs_zero_clk", all_outs, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post_rst_if", {mem_read, i_or_d, mem_write}, 3'b100);
    @(negedge clk);

    // ADD / SUB / I-type with funct7[5]
    run_instr(K_R,  ops[K_R], 3'd0, 7'h00, 0, 0, 0, h);
    run_instr(K_R,  ops[K_R], 3'd0, 7'h20, 0, 0, 0, h);
    run_instr(K_I,  ops[K_I], 3'd0, 7'h20, 0, 0, 0, h);
    // BEQ taken / not taken
    run_instr(K_BR, ops[K_BR], 3'd0, 7'h00, 1, 0, 0, h);
    run_instr(K_BR, ops[K_BR], 3'd0, 7'h00, 0, 0, 0, h);
    // LOAD with two memory wait cycles
    run_instr(K_LD, ops[K_LD], 3'd2, 7'h00, 0, 0, 2, h);
    run_instr(K_JAL, ops[K_JAL], 3'd0, 7'h00, 0, 1, 0, h);
    run_instr(K_JALR, ops[K_JALR], 3'd0, 7'h00, 0, 0, 0, h);

    // Reset in the middle of a STORE's MEM phase
    opcode = ops[K_ST]; funct3 = 3'd2; funct7 = '0; mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;  // ID
    @(negedge clk);                    // EX
    @(negedge clk);                    // MEM, memory stalled
    #1 chk("st_mem_write", {mem_write, i_or_d}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_write_drop", mem_write, 0);
    chk("rst_no_pc_write", pc_write, 0);
    chk("rst_mid_all_zero", all_outs, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("st_rst_if", {mem_read, i_or_d, mem_write}, 3'b100);
    @(negedge clk);

    // Unknown opcode and ECALL stop after ID
    run_instr(K_BAD, 7'b0000000, 3'd0, 7'h00, 0, 0, 0, h);
    if (h) begin halt_hold(10); clear_halt(); end
    run_instr(K_ECALL, ops[K_ECALL], 3'd0, 7'h00, 0, 0, 0, h);
    if (h) begin halt_hold(3); clear_halt(); end
    // SRA encoding stops after EX
    run_instr(K_I, ops[K_I], 3'd5, 7'h20, 0, 0, 0, h);
    if (h) begin halt_hold(2); clear_halt(); end

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      kind = ($urandom_range(0, 19) == 0) ? $urandom_range(K_ECALL, K_BAD)
                                          : $urandom_range(K_R, K_JALR);
      if (kind == K_BAD) begin
        do begin
          op = 7'($urandom); known = 0;
          foreach (ops[j]) if (ops[j] == op) known = 1;
        end while (known);
      end else op = ops[kind];
      f3   = 3'($urandom);
      f7   = $urandom_range(0, 1) ? 7'h20 : 7'($urandom_range(0, 31));
      wif  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      wmem = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(kind, op, f3, f7, 1'($urandom), wif, wmem, h);
      if (h) begin halt_hold(2); clear_halt(); end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
